// File: rtl/lcd_pkg.sv
// Shared constants, timing defaults, state encodings and byte-class helpers for the HD44780 write path.
// No logic of its own. No latency and no backpressure.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [6:0] LINE2_BASE    = 7'h40;
    localparam logic [6:0] LINE_LEN      = 7'd16;

    localparam int DEF_SETUP_CYC     = 5;
    localparam int DEF_E_PULSE_CYC   = 25;
    localparam int DEF_EXEC_CYC      = 2500;
    localparam int DEF_LONG_EXEC_CYC = 82000;
    localparam int CNT_W             = 17;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, DONE} lcd_state_t;
    typedef enum logic [2:0] {SEQ_IDLE, SEQ_PREFIX, SEQ_LAUNCH, SEQ_CHAR, SEQ_DONE} seq_state_t;

    // Clear and both home encodings (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(input logic [7:0] dat, input logic rs);
        return !rs && (dat == CMD_CLEAR || dat == CMD_HOME || dat == (CMD_HOME | 8'h01));
    endfunction

    function automatic logic [6:0] next_cursor(input logic [6:0] cur, input logic [7:0] dat,
                                               input logic rs);
        if (rs)
            return cur + 7'd1;
        if (is_long_cmd(dat, rs))
            return 7'd0;
        if (dat[7])
            return dat[6:0];
        return cur;
    endfunction

endpackage

// File: rtl/lcd_write_byte_if.sv
// Nios II custom-instruction handshake: clock enable, start, operands, result and done strobe.
// No latency of its own. No backpressure: the CPU waits for done.
interface lcd_write_byte_if;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic [31:0] result;
   logic        done;

   modport master (output clk_en, start, dataa, datab, input result, done);
   modport slave  (input clk_en, start, dataa, datab, output result, done);
endinterface

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write cycle: SETUP, E pulse, HOLD, then the execution wait, ending in a one-cycle done.
// Latency: 2*SETUP_CYC + E_PULSE_CYC + wait enabled clocks to done. start is accepted only in IDLE; en=0 freezes.
module lcd_bus_cycle
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC     = DEF_SETUP_CYC,
   parameter int E_PULSE_CYC   = DEF_E_PULSE_CYC,
   parameter int EXEC_CYC      = DEF_EXEC_CYC,
   parameter int LONG_EXEC_CYC = DEF_LONG_EXEC_CYC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       start,
   input  logic [7:0] tx_dat,
   input  logic       tx_rs,
   input  logic       tx_long,
   output logic       done,
   output logic       lcd_enable,
   output logic       lcd_rs,
   output logic [7:0] lcd_data
);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_EXEC_CYC - 1);

   lcd_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] wait_last;
   logic             long_q;
   logic             e_q;

   assign wait_last  = long_q ? LONG_LAST : EXEC_LAST;
   assign done       = (state == DONE);
   assign lcd_enable = e_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)               state_nxt = SETUP;
         SETUP:   if (cnt == SETUP_LAST)   state_nxt = PULSE;
         PULSE:   if (cnt == PULSE_LAST)   state_nxt = HOLD;
         HOLD:    if (cnt == SETUP_LAST)   state_nxt = WAIT;
         WAIT:    if (cnt == wait_last)    state_nxt = DONE;
         DONE:                             state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   // E is registered so the LCD pin is glitch-free; reset clears it asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         e_q      <= 1'b0;
         long_q   <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= 8'h00;
      end else if (en) begin
         state <= state_nxt;
         e_q   <= (state_nxt == PULSE);
         cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
         if (state == IDLE && start) begin
            lcd_data <= tx_dat;
            lcd_rs   <= tx_rs;
            long_q   <= tx_long;
         end
      end
   end

endmodule

// File: rtl/lcd_write_byte.sv
// Custom instruction writing one command/character byte to an HD44780 LCD; LCD_WRITE_CURSOR_TRACK_EN adds line-wrap cursor tracking.
// Latency: 2*SETUP_CYC + E_PULSE_CYC + wait + 1 enabled clocks to done. start ignored while busy; clk_en=0 freezes everything.
module lcd_write_byte
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC     = DEF_SETUP_CYC,
   parameter int E_PULSE_CYC   = DEF_E_PULSE_CYC,
   parameter int EXEC_CYC      = DEF_EXEC_CYC,
   parameter int LONG_EXEC_CYC = DEF_LONG_EXEC_CYC
) (
   input  logic             clk,
   input  logic             reset,
   lcd_write_byte_if.slave  ci,
   output logic             lcd_enable,
   output logic             lcd_rs,
   output logic             lcd_rw,
   output logic [7:0]       lcd_data
);

   seq_state_t  seq, seq_nxt;
   logic [7:0]  char_q;
   logic        rs_q;
   logic [31:0] result_q, result_nxt;
   logic        bus_start, bus_rs, bus_long, bus_done;
   logic [7:0]  bus_dat;
   logic        need_prefix;
   logic [7:0]  prefix_dat;
   logic        unused_bits;

   assign unused_bits = ^{ci.dataa[31:8], ci.datab[31:1]};
   assign lcd_rw      = 1'b0;
   assign ci.done     = (seq == SEQ_DONE);
   assign ci.result   = result_q;

`ifdef LCD_WRITE_CURSOR_TRACK_EN
   logic [6:0] cursor, cursor_nxt;

   // A character landing just past the end of a line first repositions DDRAM to the next line.
   assign need_prefix = ci.datab[0] && (cursor == LINE_LEN || cursor == LINE2_BASE + LINE_LEN);
   assign prefix_dat  = CMD_SET_DDRAM | {1'b0, (cursor == LINE_LEN) ? LINE2_BASE : 7'h00};
   assign cursor_nxt  = next_cursor(cursor, char_q, rs_q);
   assign result_nxt  = {17'd0, cursor_nxt, char_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cursor <= 7'h00;
      else if (ci.clk_en && bus_done) begin
         if (seq == SEQ_PREFIX)
            cursor <= next_cursor(cursor, prefix_dat, 1'b0);
         else if (seq == SEQ_CHAR)
            cursor <= cursor_nxt;
      end
   end
`else
   assign need_prefix = 1'b0;
   assign prefix_dat  = CMD_SET_DDRAM;
   assign result_nxt  = {24'd0, char_q};
`endif

   always_comb begin
      seq_nxt   = seq;
      bus_start = 1'b0;
      bus_dat   = char_q;
      bus_rs    = rs_q;
      bus_long  = is_long_cmd(char_q, rs_q);
      case (seq)
         SEQ_IDLE: begin
            if (ci.start) begin
               bus_start = 1'b1;
               if (need_prefix) begin
                  bus_dat  = prefix_dat;
                  bus_rs   = 1'b0;
                  bus_long = 1'b0;
                  seq_nxt  = SEQ_PREFIX;
               end else begin
                  bus_dat  = ci.dataa[7:0];
                  bus_rs   = ci.datab[0];
                  bus_long = is_long_cmd(ci.dataa[7:0], ci.datab[0]);
                  seq_nxt  = SEQ_CHAR;
               end
            end
         end
         SEQ_PREFIX: if (bus_done) seq_nxt = SEQ_LAUNCH;
         SEQ_LAUNCH: begin
            bus_start = 1'b1;
            seq_nxt   = SEQ_CHAR;
         end
         SEQ_CHAR:   if (bus_done) seq_nxt = SEQ_DONE;
         SEQ_DONE:   seq_nxt = SEQ_IDLE;
         default:    seq_nxt = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq      <= SEQ_IDLE;
         char_q   <= 8'h00;
         rs_q     <= 1'b0;
         result_q <= '0;
      end else if (ci.clk_en) begin
         seq <= seq_nxt;
         if (seq == SEQ_IDLE && ci.start) begin
            char_q <= ci.dataa[7:0];
            rs_q   <= ci.datab[0];
         end
         if (seq == SEQ_CHAR && bus_done)
            result_q <= result_nxt;
      end
   end

   lcd_bus_cycle #(
      .SETUP_CYC     (SETUP_CYC),
      .E_PULSE_CYC   (E_PULSE_CYC),
      .EXEC_CYC      (EXEC_CYC),
      .LONG_EXEC_CYC (LONG_EXEC_CYC)
   ) u_bus (
      .clk        (clk),
      .reset      (reset),
      .en         (ci.clk_en),
      .start      (bus_start),
      .tx_dat     (bus_dat),
      .tx_rs      (bus_rs),
      .tx_long    (bus_long),
      .done       (bus_done),
      .lcd_enable (lcd_enable),
      .lcd_rs     (lcd_rs),
      .lcd_data   (lcd_data)
   );

endmodule

// File: tb/tb_lcd_write_byte.sv
// Directed bench for lcd_write_byte with short timing; cursor-wrap steps run when LCD_WRITE_CURSOR_TRACK_EN is defined.
module tb_lcd_write_byte;

`ifdef LCD_WRITE_CURSOR_TRACK_EN
`define RES(c, b) {17'd0, 7'(c), 8'(b)}
`else
`define RES(c, b) {24'd0, 8'(b)}
`endif

   localparam int SU = 2, EP = 4, EX = 10, LX = 40;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       lcd_enable, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;

   lcd_write_byte_if ci ();

   lcd_write_byte #(
      .SETUP_CYC(SU), .E_PULSE_CYC(EP), .EXEC_CYC(EX), .LONG_EXEC_CYC(LX)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ci         (ci),
      .lcd_enable (lcd_enable),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_data   (lcd_data)
   );

   always #5 clk = ~clk;

   int         checks = 0, errors = 0;
   int         en_cnt, e_first, e_raw, e_pulses, done_at, done_num;
   logic [7:0] first_dat, last_e_dat;
   logic       first_rs, last_e_rs, e_prev, d_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one request and measure E pulses / done in enabled-clock units counted from the start edge.
   task automatic xfer(input string nm, input logic [7:0] b, input logic rs, input bit tog,
                       input int restart_at, input logic [7:0] exp_first, input int exp_done,
                       input int exp_pulses, input int exp_raw, input logic [31:0] exp_res);
      logic exp_first_rs;
      exp_first_rs = (exp_pulses == 1) ? rs : 1'b0;
      ci.dataa  = {24'hA5C3F0, b};
      ci.datab  = {31'h2AAAAAAA, rs};
      ci.clk_en = 1'b1;
      ci.start  = 1'b1;
      tick;
      ci.start  = 1'b0;
      first_dat = lcd_data;
      first_rs  = lcd_rs;
      en_cnt = 0; e_first = -1; e_raw = 0; e_pulses = 0; done_at = -1; done_num = 0;
      e_prev = 1'b0; d_prev = 1'b0; last_e_dat = 8'h00; last_e_rs = 1'b0;
      for (int t = 1; t <= 400; t++) begin
         ci.clk_en = tog ? (t % 2 == 0) : 1'b1;
         ci.start  = ci.clk_en && (en_cnt + 1 == restart_at);
         tick;
         if (ci.clk_en) en_cnt++;
         if (lcd_enable) begin
            e_raw++;
            if (e_first < 0) e_first = en_cnt;
            if (!e_prev) begin
               e_pulses++;
               last_e_dat = lcd_data;
               last_e_rs  = lcd_rs;
            end
         end
         if (ci.done && !d_prev) begin
            done_num++;
            if (done_at < 0) done_at = en_cnt;
         end
         e_prev = lcd_enable;
         d_prev = ci.done;
         if (done_at >= 0 && en_cnt >= done_at + 5) break;
      end
      ci.start  = 1'b0;
      ci.clk_en = 1'b1;
      check({nm, ".first_dat"}, 32'(first_dat), 32'(exp_first));
      check({nm, ".first_rs"}, 32'(first_rs), 32'(exp_first_rs));
      check({nm, ".e_first"}, e_first, SU);
      check({nm, ".e_raw"}, e_raw, exp_raw);
      check({nm, ".e_pulses"}, e_pulses, exp_pulses);
      check({nm, ".e_dat"}, 32'(last_e_dat), 32'(b));
      check({nm, ".e_rs"}, 32'(last_e_rs), 32'(rs));
      check({nm, ".done_at"}, done_at, exp_done);
      check({nm, ".done_num"}, done_num, 1);
      check({nm, ".result"}, ci.result, exp_res);
      check({nm, ".rw"}, 32'(lcd_rw), 0);
   endtask

   initial begin
      ci.clk_en = 1'b1;
      ci.start  = 1'b0;
      ci.dataa  = '0;
      ci.datab  = '0;
      reset     = 1'b1;
      tick;
      tick;
      check("reset.e", 32'(lcd_enable), 0);
      check("reset.rs", 32'(lcd_rs), 0);
      check("reset.data", 32'(lcd_data), 0);
      check("reset.rw", 32'(lcd_rw), 0);
      check("reset.done", 32'(ci.done), 0);
      check("reset.result", ci.result, 0);
      reset = 1'b0;
      tick;

      xfer("char41",  8'h41, 1'b1, 1'b0, -1, 8'h41, 19, 1, 4, `RES(1, 8'h41));
      xfer("clear",   8'h01, 1'b0, 1'b0, -1, 8'h01, 49, 1, 4, `RES(0, 8'h01));
      xfer("fnset",   8'h38, 1'b0, 1'b0, -1, 8'h38, 19, 1, 4, `RES(0, 8'h38));
      xfer("home3",   8'h03, 1'b0, 1'b0, -1, 8'h03, 49, 1, 4, `RES(0, 8'h03));
      xfer("entry4",  8'h04, 1'b0, 1'b0, -1, 8'h04, 19, 1, 4, `RES(0, 8'h04));
      xfer("char01",  8'h01, 1'b1, 1'b0, -1, 8'h01, 19, 1, 4, `RES(1, 8'h01));
      xfer("clken",   8'h42, 1'b1, 1'b1, -1, 8'h42, 19, 1, 8, `RES(2, 8'h42));
      xfer("restart", 8'h43, 1'b1, 1'b0, 12, 8'h43, 19, 1, 4, `RES(3, 8'h43));

      // Reset while E is high: E and every output drop before the next edge, no done follows.
      ci.dataa = 32'h0000_0033;
      ci.datab = 32'h0000_0001;
      ci.start = 1'b1;
      tick;
      ci.start = 1'b0;
      tick;
      tick;
      tick;
      check("rst.e_before", 32'(lcd_enable), 1);
      #2 reset = 1'b1;
      #1;
      check("rst.e", 32'(lcd_enable), 0);
      check("rst.done", 32'(ci.done), 0);
      check("rst.result", ci.result, 0);
      check("rst.data", 32'(lcd_data), 0);
      check("rst.rs", 32'(lcd_rs), 0);
      tick;
      reset = 1'b0;
      done_num = 0;
      e_raw = 0;
      for (int t = 0; t < 60; t++) begin
         tick;
         if (ci.done) done_num++;
         if (lcd_enable) e_raw++;
      end
      check("rst.no_done", done_num, 0);
      check("rst.no_e", e_raw, 0);

      xfer("post_rst", 8'h44, 1'b1, 1'b0, -1, 8'h44, 19, 1, 4, `RES(1, 8'h44));

`ifdef LCD_WRITE_CURSOR_TRACK_EN
      for (int i = 0; i < 15; i++)
         xfer("fill", 8'(8'h61 + i), 1'b1, 1'b0, -1, 8'(8'h61 + i), 19, 1, 4,
              {17'd0, 7'(i + 2), 8'(8'h61 + i)});
      xfer("wrap1", 8'h5A, 1'b1, 1'b0, -1, 8'hC0, 39, 2, 8, {17'd0, 7'h41, 8'h5A});
      xfer("setd0", 8'hD0, 1'b0, 1'b0, -1, 8'hD0, 19, 1, 4, {17'd0, 7'h50, 8'hD0});
      xfer("wrap2", 8'h21, 1'b1, 1'b0, -1, 8'h80, 39, 2, 8, {17'd0, 7'h01, 8'h21});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
